// File: rtl/cpu_io_pkg.sv
// Shared types for the Z80 I/O-bus bridge: FSM states, posted-write entry, default port base.
package cpu_io_pkg;

  localparam logic [7:0] BASE_ADDR_DEF = 8'h98;
  localparam int         OFFSET_MAX_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RD_HOLD
  } state_t;

  // Offset is sized for the widest possible window and zero-extended on entry.
  typedef struct packed {
    logic [OFFSET_MAX_W-1:0] offset;
    logic [7:0]              data;
  } fifo_entry_t;

endpackage

// File: rtl/io_strobe_filter.sv
// 2-flop synchroniser plus run-length filter for one active-low strobe, with a payload
// carried through the same two flops so it stays aligned with the strobe.
module io_strobe_filter #(
  parameter int FILTER_LEN = 4,
  parameter int DATA_W     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe_n_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              filt_n_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic              s1_q, s2_q, filt_q;
  logic [DATA_W-1:0] d1_q, d2_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      d1_q   <= '0;
      d2_q   <= '0;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q <= strobe_n_i;
      s2_q <= s1_q;
      d1_q <= data_i;
      d2_q <= d1_q;
      // Output flips on the FILTER_LEN-th consecutive differing sample.
      if (s2_q != filt_q) begin
        if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
          filt_q <= s2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign filt_n_o = filt_q;
  assign data_o   = d2_q;

endmodule

// File: rtl/cpu_io_bridge.sv
// Z80 I/O-bus front end for the VDP: port decode, filtered strobes, posted-write FIFO,
// and read serialisation behind pending writes with wait_n stretching.
module cpu_io_bridge
  import cpu_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int         PORT_BITS  = 2,
  parameter int         FILTER_LEN = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter int         ADR_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           addr,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  output logic                 dout_oe,
  output logic                 cs_n,
  output logic                 wait_n,
  output logic                 req,
  output logic                 wrt,
  output logic [ADR_WIDTH-1:0] adr,
  output logic [7:0]           dbo,
  input  logic                 ack,
  input  logic [7:0]           dbi,
  output logic                 overflow
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [7:0] HI_MASK = 8'hFF << PORT_BITS;

  logic                 hit;
  logic                 wr_filt_n, rd_filt_n, wr_prev_q, rd_prev_q, wr_fall, rd_fall;
  logic [PORT_BITS-1:0] wr_off, rd_off, rd_off_q;
  logic [7:0]           wr_data;
  fifo_entry_t          mem_q [FIFO_DEPTH];
  fifo_entry_t          push_entry, head;
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic                 full, empty, pop, push;
  state_t               state_q;
  logic                 req_q, wrt_q, wait_n_q, rd_pend_q, overflow_q;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [7:0]           dbo_q, dout_q;

  assign hit     = ((addr & HI_MASK) == (BASE_ADDR & HI_MASK)) && !iorq_n;
  assign cs_n    = ~hit;
  assign dout_oe = hit & ~rd_n;

  io_strobe_filter #(.FILTER_LEN(FILTER_LEN), .DATA_W(PORT_BITS + 8)) u_wr_filt (
    .clk       (clk),
    .rst_n     (reset_n),
    .strobe_n_i(~(hit & ~wr_n)),
    .data_i    ({addr[PORT_BITS-1:0], din}),
    .filt_n_o  (wr_filt_n),
    .data_o    ({wr_off, wr_data})
  );

  io_strobe_filter #(.FILTER_LEN(FILTER_LEN), .DATA_W(PORT_BITS)) u_rd_filt (
    .clk       (clk),
    .rst_n     (reset_n),
    .strobe_n_i(~(hit & ~rd_n)),
    .data_i    (addr[PORT_BITS-1:0]),
    .filt_n_o  (rd_filt_n),
    .data_o    (rd_off)
  );

  assign wr_fall = wr_prev_q & ~wr_filt_n;
  assign rd_fall = rd_prev_q & ~rd_filt_n;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = (state_q == WRITE) && ack;
  // A pop in the same cycle frees the slot the push lands in.
  assign push  = wr_fall && (!full || pop);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_entry.offset = OFFSET_MAX_W'(wr_off);
  assign push_entry.data   = wr_data;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_q  <= 1'b1;
      rd_prev_q  <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      req_q      <= 1'b0;
      wrt_q      <= 1'b0;
      adr_q      <= '0;
      dbo_q      <= '0;
      dout_q     <= '0;
      wait_n_q   <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_off_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_prev_q <= wr_filt_n;
      rd_prev_q <= rd_filt_n;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (wr_fall && full && !pop) overflow_q <= 1'b1;
      if (rd_fall && state_q != RD_HOLD) begin
        rd_pend_q <= 1'b1;
        wait_n_q  <= 1'b0;
        rd_off_q  <= rd_off;
      end
      case (state_q)
        IDLE: begin
          if (!empty) begin
            adr_q   <= ADR_WIDTH'(head.offset);
            dbo_q   <= head.data;
            wrt_q   <= 1'b1;
            req_q   <= 1'b1;
            state_q <= WRITE;
          end else if (rd_pend_q) begin
            adr_q   <= ADR_WIDTH'(rd_off_q);
            wrt_q   <= 1'b0;
            req_q   <= 1'b1;
            state_q <= READ;
          end
        end
        WRITE: begin
          if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            req_q    <= 1'b0;
            state_q  <= IDLE;
          end
        end
        READ: begin
          if (ack) begin
            dout_q    <= dbi;
            req_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            wait_n_q  <= 1'b1;
            state_q   <= RD_HOLD;
          end
        end
        RD_HOLD: begin
          // Wait for RD to end so one long strobe never issues a second read.
          if (rd_filt_n) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout     = dout_q;
  assign wait_n   = wait_n_q;
  assign req      = req_q;
  assign wrt      = wrt_q;
  assign adr      = adr_q;
  assign dbo      = dbo_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed bench for cpu_io_bridge: decode, write posting, glitch rejection, overflow,
// read ordering, long reads and reset during a read.
module tb_cpu_io_bridge;

  logic        clk;
  logic        reset_n;
  logic [7:0]  addr;
  logic        iorq_n, rd_n, wr_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_oe, cs_n, wait_n, req, wrt;
  logic [15:0] adr;
  logic [7:0]  dbo;
  logic        ack;
  logic [7:0]  dbi;
  logic        overflow;

  int          vectors = 0;
  int          miscompares = 0;
  logic        auto_ack = 1'b0;

  logic [15:0] log_adr [32];
  logic        log_wrt [32];
  logic [7:0]  log_dbo [32];
  int          log_n = 0;

  cpu_io_bridge dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .iorq_n  (iorq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .din     (din),
    .dout    (dout),
    .dout_oe (dout_oe),
    .cs_n    (cs_n),
    .wait_n  (wait_n),
    .req     (req),
    .wrt     (wrt),
    .adr     (adr),
    .dbo     (dbo),
    .ack     (ack),
    .dbi     (dbi),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VDP model: single-cycle ack one cycle after req when enabled.
  always @(negedge clk) begin
    if (auto_ack && req && !ack) ack <= 1'b1;
    else                         ack <= 1'b0;
  end

  always @(posedge clk) begin
    if (req === 1'b1 && ack === 1'b1 && log_n < 32) begin
      log_adr[log_n] <= adr;
      log_wrt[log_n] <= wrt;
      log_dbo[log_n] <= dbo;
      log_n          <= log_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int low);
    @(negedge clk);
    addr = a; din = d; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (low) @(negedge clk);
    wr_n = 1'b1; iorq_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; addr = 8'h00; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    din = 8'h00; dbi = 8'h00; ack = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", req, 0);
    check("rst_wait_n", wait_n, 1);
    check("rst_dout", dout, 0);
    check("rst_dout_oe", dout_oe, 0);
    check("rst_wrt", wrt, 0);
    check("rst_adr", adr, 0);
    check("rst_dbo", dbo, 0);
    check("rst_overflow", overflow, 0);
    check("rst_cs_n", cs_n, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single write, checking req latency of 2+FILTER_LEN+2 cycles
    auto_ack = 1'b1;
    addr = 8'h99; din = 8'h8F; iorq_n = 1'b0; wr_n = 1'b0;
    #1 check("wr1_cs_n", cs_n, 0);
    repeat (7) @(posedge clk);
    #1 check("wr1_req_early", req, 0);
    @(posedge clk);
    #1;
    check("wr1_req", req, 1);
    check("wr1_wrt", wrt, 1);
    check("wr1_adr", adr, 1);
    check("wr1_dbo", dbo, 8'h8F);
    repeat (2) @(negedge clk);
    wr_n = 1'b1; iorq_n = 1'b1;
    repeat (20) @(negedge clk);
    check("wr1_count", log_n, 1);
    check("wr1_log_wrt", log_wrt[0], 1);
    check("wr1_log_adr", log_adr[0], 1);
    check("wr1_log_dbo", log_dbo[0], 8'h8F);

    // Glitch shorter than the filter is rejected
    do_write(8'h98, 8'h55, 3);
    repeat (12) @(negedge clk);
    check("glitch_count", log_n, 1);
    check("glitch_req", req, 0);

    // Decode: outside the window, then a short in-window read strobe
    addr = 8'h9C; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("miss_cs_n", cs_n, 1);
    check("miss_dout_oe", dout_oe, 0);
    repeat (10) @(negedge clk);
    check("miss_wait_n", wait_n, 1);
    check("miss_req", req, 0);
    rd_n = 1'b1; addr = 8'h9B;
    #1 check("hit_rdhigh_dout_oe", dout_oe, 0);
    rd_n = 1'b0;
    #1 check("hit_dout_oe", dout_oe, 1);
    @(negedge clk);
    rd_n = 1'b1; iorq_n = 1'b1;
    repeat (12) @(negedge clk);
    check("short_rd_wait_n", wait_n, 1);
    check("short_rd_count", log_n, 1);

    // Overflow: five writes with ack held off
    auto_ack = 1'b0;
    for (int i = 1; i <= 4; i++) do_write(8'h9A, 8'(i), 8);
    check("ovf_before", overflow, 0);
    do_write(8'h9A, 8'h05, 8);
    check("ovf_set", overflow, 1);
    check("ovf_req_held", req, 1);
    check("ovf_adr_held", adr, 2);
    check("ovf_dbo_held", dbo, 8'h01);
    auto_ack = 1'b1;
    repeat (30) @(negedge clk);
    check("ovf_count", log_n, 5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_order%0d", i), log_dbo[1+i], 32'(i + 1));
      check($sformatf("ovf_wrt%0d", i), log_wrt[1+i], 1);
    end
    check("ovf_sticky", overflow, 1);

    // Read waits behind two posted writes
    auto_ack = 1'b0;
    do_write(8'h98, 8'h11, 8);
    do_write(8'h98, 8'h22, 8);
    addr = 8'h99; iorq_n = 1'b0; rd_n = 1'b0; dbi = 8'h5A;
    repeat (12) @(negedge clk);
    check("ord_wait_low", wait_n, 0);
    check("ord_req_wr", wrt, 1);
    check("ord_dbo_first", dbo, 8'h11);
    auto_ack = 1'b1;
    repeat (20) @(negedge clk);
    check("ord_count", log_n, 8);
    check("ord_w1", {log_wrt[5], log_adr[5], log_dbo[5]}, {1'b1, 16'd0, 8'h11});
    check("ord_w2", {log_wrt[6], log_adr[6], log_dbo[6]}, {1'b1, 16'd0, 8'h22});
    check("ord_rd_wrt", log_wrt[7], 0);
    check("ord_rd_adr", log_adr[7], 1);
    check("ord_dout", dout, 8'h5A);
    check("ord_wait_rel", wait_n, 1);
    check("ord_dout_oe", dout_oe, 1);
    rd_n = 1'b1; iorq_n = 1'b1;
    repeat (10) @(negedge clk);

    // Long read issues exactly one access
    dbi = 8'hC3;
    addr = 8'h9B; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (50) @(negedge clk);
    check("long_count", log_n, 9);
    check("long_wrt", log_wrt[8], 0);
    check("long_adr", log_adr[8], 3);
    check("long_dout", dout, 8'hC3);
    check("long_wait_n", wait_n, 1);
    check("long_req", req, 0);
    rd_n = 1'b1; iorq_n = 1'b1;
    repeat (20) @(negedge clk);
    check("long_count_after", log_n, 9);

    // Reset while in READ, with a write posted during the read
    auto_ack = 1'b0;
    dbi = 8'hEE;
    addr = 8'h98; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_req", req, 1);
    check("mid_wrt", wrt, 0);
    check("mid_wait_n", wait_n, 0);
    din = 8'h77; wr_n = 1'b0;
    repeat (10) @(negedge clk);
    wr_n = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_req", req, 0);
    check("mrst_wait_n", wait_n, 1);
    check("mrst_overflow", overflow, 0);
    iorq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    auto_ack = 1'b1;
    repeat (20) @(negedge clk);
    check("mrst_fifo_empty", req, 0);
    check("mrst_count", log_n, 9);
    dbi = 8'h3C;
    addr = 8'h9A; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (15) @(negedge clk);
    check("post_count", log_n, 10);
    check("post_wrt", log_wrt[9], 0);
    check("post_adr", log_adr[9], 2);
    check("post_dout", dout, 8'h3C);
    check("post_wait_n", wait_n, 1);
    rd_n = 1'b1; iorq_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
- Parametrised Z80 I/O-bus front end for the VDP core. Replaces the fixed single-shot CpuReq/CpuWrt latch logic at the top level.
- Decodes a configurable port window and synchronises and glitch-filters the chip-select strobes.
- Posts CPU writes into a small FIFO and issues them to the VDP over a req/ack handshake.
- Serialises reads behind pending writes, holding the Z80 with wait_n until read data is valid.

Parameters:
- BASE_ADDR, 8'h98: first I/O port of the window; must be aligned to 2**PORT_BITS.
- PORT_BITS, 2: number of decoded low address bits; the window is 2**PORT_BITS ports.
- FILTER_LEN, 4: consecutive identical samples (in clk cycles) required before a filtered strobe changes; minimum 1.
- FIFO_DEPTH, 4: number of posted-write entries; power of two, minimum 2.
- ADR_WIDTH, 16: width of adr toward the VDP; must be at least PORT_BITS.

Ports:
- clk  in  1  21.477 MHz VDP clock.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  8  Z80 A[7:0].
- iorq_n  in  1  Z80 IORQ, asynchronous.
- rd_n  in  1  Z80 RD, asynchronous.
- wr_n  in  1  Z80 WR, asynchronous.
- din  in  8  Z80 data bus, input side.
- dout  out  8  read data toward the Z80 data bus.
- dout_oe  out  1  enable for the tristate data-bus driver.
- cs_n  out  1  board chip-select (transceiver enable).
- wait_n  out  1  Z80 WAIT, active low; the top level drives it open-drain.
- req  out  1  VDP request, held high until ack.
- wrt  out  1  1 = write, 0 = read; valid while req is high.
- adr  out  ADR_WIDTH  port offset, zero-extended; valid while req is high.
- dbo  out  8  write data; valid while req is high.
- ack  in  1  single-cycle acceptance from the VDP; on reads, dbi is valid in the same cycle.
- dbi  in  8  VDP read data.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset values: dout=0, dout_oe=0, wait_n=1, req=0, wrt=0, adr=0, dbo=0, overflow=0. The FIFO is emptied and the FSM enters IDLE. Reset is asynchronous on assertion; deassertion is used as-is because the top level already synchronises it.
- Decode is combinational from the raw pins:
  - hit = (addr[7:PORT_BITS] == BASE_ADDR[7:PORT_BITS]) & ~iorq_n.
  - cs_n = ~hit.
  - dout_oe = hit & ~rd_n.
- Strobes: csw_n = ~(hit & ~wr_n) and csr_n = ~(hit & ~rd_n). Each passes through a 2-flop synchroniser, then a filter. A filtered output toggles only after FILTER_LEN consecutive samples differ from its current value. Filter reset state is 1.
- Capture point:
  - din and addr[PORT_BITS-1:0] are registered through the same 2-flop path, so they stay aligned with the strobes.
  - The value captured is the one present in the cycle the filtered strobe falls. That cycle is 2+FILTER_LEN cycles after the raw strobe becomes stable.
- Write posting: on the falling edge of filtered csw_n, push {offset, data}.
  - If the FIFO is full, drop the entry and set overflow; overflow is cleared only by reset.
  - A push and a pop in the same cycle are both legal, including when the FIFO is full (the pop frees a slot first).
- Read detect: on the falling edge of filtered csr_n, set rd_pend and drive wait_n=0 in the next cycle. Raw rd timing is not shortened.
- FSM states:
  - IDLE: if the FIFO is not empty, load its head into adr/dbo, set wrt=1 and req=1, go to WRITE. Otherwise, if rd_pend, set wrt=0 and req=1, go to READ. Writes always take priority, so a read observes all earlier writes.
  - WRITE: hold req and the output fields. On ack, pop the FIFO, drop req, return to IDLE. The next req can rise one cycle later at the earliest.
  - READ: on ack, latch dbi into dout, drop req, clear rd_pend, release wait_n (wait_n=1 in the next cycle), go to RD_HOLD.
  - RD_HOLD: stay until filtered csr_n is high, then return to IDLE. This prevents one long RD from issuing two reads.
- dout holds its value until the next read ack. dout_oe is independent of dout validity; wait_n guarantees the Z80 samples only valid data.
- Simultaneous events:
  - A write edge during READ is pushed normally.
  - ack arriving while req=0 is ignored.
  - A read edge during RD_HOLD is impossible by construction; if it occurs anyway, it is ignored.
- Reset mid-transaction: req, wait_n and the FIFO are cleared immediately. Any in-flight VDP access is abandoned; the VDP is reset on the same reset.

Decomposition:
- Package cpu_io_pkg holds:
  - the FSM state enum (IDLE, WRITE, READ, RD_HOLD);
  - the FIFO entry struct {offset [PORT_BITS-1:0], data [7:0]};
  - the default BASE_ADDR constant.
- Sub-module io_strobe_filter (parameter FILTER_LEN; 2-flop synchroniser plus filter), instantiated once per strobe. It replaces PINFILTER in this path.
- The FIFO is inline: a register array with read/write pointers one bit wider than the index.

Test Plan:
- Single write: port 0x99, data 0x8F, stable for 10 cycles, ack returned one cycle after req → exactly one req with wrt=1, adr=1, dbo=0x8F. req rises 2+FILTER_LEN+2 cycles after wr_n falls.
- Glitch rejection: wr_n low for FILTER_LEN-1 cycles at 0x98 → no push and no req. Address 0x9C with rd_n low → cs_n=1, dout_oe=0.
- Overflow: FIFO_DEPTH=4, ack held low, five writes of 0x01..0x05 → overflow=1. Once ack is released, writes 0x01..0x04 are issued in order and 0x05 is never seen.
- Read ordering: two writes pending, then a read of port 0x99 with dbi=0x5A → wait_n=0, both writes acked, then a req with wrt=0 and adr=1. dout=0x5A and wait_n=1 follow the ack.
- Long read: rd_n held low for 50 cycles → exactly one read req, then the FSM waits in RD_HOLD.
- Reset mid-read: reset_n pulled low while in READ → req=0, wait_n=1, FIFO empty, overflow=0 in the same cycle. The next read works normally.
